// File: rtl/ram_seg_scanner_pkg.sv
// ram_seg_scanner_pkg
// Shared definitions for the RAM-fed 7-segment display scanner:
//   - RAM address/data widths
//   - active-low segment patterns for blank and dash
//   - fetch/convert FSM state encoding (2 bits)
//   - pow10() helper for sizing the binary-to-BCD converter
package ram_seg_scanner_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_LOAD    = 2'd3
    } state_t;

    // 10^n for small n (n <= 9 fits comfortably in 32 bits).
    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/ram_seg_scanner_seg7_decode.sv
// seg7_decode
// Combinational BCD digit to active-low 7-segment decoder.
// Ports:
//   bcd  [3:0] in  : digit value; 10..15 decode to blank
//   dash       in  : force the dash pattern regardless of bcd
//   seg  [6:0] out : segments, active-low, seg[6]=A .. seg[0]=G
module seg7_decode
    import ram_seg_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (bcd)
                4'd0:    seg = 7'b0000001;
                4'd1:    seg = 7'b1001111;
                4'd2:    seg = 7'b0010010;
                4'd3:    seg = 7'b0000110;
                4'd4:    seg = 7'b1001100;
                4'd5:    seg = 7'b0100100;
                4'd6:    seg = 7'b0100000;
                4'd7:    seg = 7'b0001111;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0000100;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ram_seg_scanner.sv
// ram_seg_scanner
// Periodically reads one 32-bit word from the data RAM, converts it to
// decimal with a bit-serial double-dabble and drives a multiplexed,
// active-low, multi-digit 7-segment display.
// Ports:
//   clock          in  : sole clock, rising edge
//   reset          in  : synchronous active-high reset
//   rd_gnt         in  : RAM read port granted this cycle
//   addr     [9:0] out : RAM read address (always BASE_ADDR)
//   result  [31:0] in  : RAM read data, combinational from addr
//   seg      [6:0] out : segments, active-low
//   an  [DIGITS-1:0] out : digit enables, active-low, an[0] = LSD
//   busy           out : fetch/convert FSM not idle
//   overflow       out : last captured value does not fit in DIGITS digits
module ram_seg_scanner
    import ram_seg_scanner_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                DIGITS      = 4,
    parameter int                REFRESH_DIV = 50000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rd_gnt,
    output logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  result,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  an,
    output logic               busy,
    output logic               overflow
);

    localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(pow10(DIGITS) - 1);
    localparam int CONV_W = $clog2(pow10(DIGITS));
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(CONV_W + 1);
    localparam int DIV_W  = $clog2(REFRESH_DIV);
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state_q, state_d;
    logic [CONV_W-1:0]  val_q, val_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               disp_dash_q, disp_dash_d;
    logic               ovf_q, ovf_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic               first_q, first_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [3:0]         disp_nib [DIGITS];
    logic [6:0]         dec_seg;
    logic               div_wrap;
    logic               last_dig;
    logic               refresh_req;

    // Double-dabble add-3 correction, applied to every nibble before the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
        assign disp_nib[gi] = disp_q[4*gi +: 4];
    end

    seg7_decode u_dec (
        .bcd  (disp_nib[dig_q]),
        .dash (disp_dash_q),
        .seg  (dec_seg)
    );

    // Scan counters run regardless of the FSM. A refresh is requested once
    // per full digit sweep, plus once right after reset so the display does
    // not wait a whole sweep for its first value.
    always_comb begin
        div_wrap    = (div_q == DIV_W'(REFRESH_DIV - 1));
        last_dig    = (dig_q == DIG_W'(DIGITS - 1));
        refresh_req = (div_wrap && last_dig) || first_q;
        first_d     = 1'b0;

        div_d = div_wrap ? '0 : div_q + 1'b1;
        dig_d = dig_q;
        an_d  = an_q;
        seg_d = seg_q;
        if (div_wrap) begin
            dig_d = last_dig ? '0 : dig_q + 1'b1;
            an_d  = ~(DIGITS'(1) << dig_q);
            seg_d = dec_seg;
        end
    end

    // Fetch / convert FSM. The display copy disp_q is only written in LOAD,
    // so the scan never sees a half-converted value.
    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        disp_d      = disp_q;
        disp_dash_d = disp_dash_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (refresh_req) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (rd_gnt) begin
                    val_d      = result[CONV_W-1:0];
                    ovf_pend_d = (result > MAX_VAL);
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bcd_d = (bcd_adj << 1) | BCD_W'(val_q[CONV_W-1]);
                val_d = val_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CONV_W - 1)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                disp_d      = bcd_q;
                disp_dash_d = ovf_pend_q;
                ovf_d       = ovf_pend_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            val_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            disp_q      <= '0;
            disp_dash_q <= 1'b0;
            ovf_q       <= 1'b0;
            div_q       <= '0;
            dig_q       <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= '1;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            disp_q      <= disp_d;
            disp_dash_q <= disp_dash_d;
            ovf_q       <= ovf_d;
            div_q       <= div_d;
            dig_q       <= dig_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            first_q     <= first_d;
        end
    end

    assign addr     = BASE_ADDR;
    assign seg      = seg_q;
    assign an       = an_q;
    assign busy     = (state_q != ST_IDLE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ram_seg_scanner.sv
// tb_ram_seg_scanner
// Directed-plus-random bench for ram_seg_scanner (DIGITS=4, REFRESH_DIV=16).
// Expected segment patterns come from decimal arithmetic on the value the
// bench presented at capture time, not from the DUT.
module tb_ram_seg_scanner;

    localparam logic [9:0] BASE = 10'h2A5;

    logic        clock;
    logic        reset;
    logic        rd_gnt;
    logic [31:0] result;
    logic [9:0]  addr;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        overflow;

    int n_cmp = 0;
    int n_mis = 0;
    logic [6:0] seg_tab [0:9];

    ram_seg_scanner #(
        .BASE_ADDR   (BASE),
        .DIGITS      (4),
        .REFRESH_DIV (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rd_gnt   (rd_gnt),
        .addr     (addr),
        .result   (result),
        .seg      (seg),
        .an       (an),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected pattern for decimal digit position d of value v.
    function automatic logic [6:0] exp_seg(input logic [31:0] v, input int d);
        logic [31:0] pw;
        logic [31:0] digit;
        if (v > 32'd9999) return 7'b1111110;
        pw = 1;
        for (int i = 0; i < d; i++) pw = pw * 10;
        digit = (v / pw) % 10;
        return seg_tab[digit];
    endfunction

    task automatic wait_busy(input logic lvl, input string tag);
        int guard;
        guard = 0;
        while (busy !== lvl && guard < 300) begin
            step();
            guard++;
        end
        chk({tag, "_wait_busy"}, 32'(busy), 32'(lvl));
    endtask

    // Observe four digit-scan updates and compare each against value v.
    task automatic check_display(input logic [31:0] v, input string tag);
        logic [3:0] prev_an;
        int seen, guard, nz, idx, prev_idx;
        prev_an  = an;
        seen     = 0;
        guard    = 0;
        prev_idx = -1;
        while (seen < 4 && guard < 200) begin
            step();
            guard++;
            if (an !== prev_an) begin
                prev_an = an;
                seen++;
                nz  = 0;
                idx = 0;
                for (int i = 0; i < 4; i++) begin
                    if (an[i] === 1'b0) begin
                        nz++;
                        idx = i;
                    end
                end
                chk($sformatf("%s_an_onehot", tag), 32'(nz), 32'd1);
                if (nz == 1) begin
                    chk($sformatf("%s_seg_d%0d", tag, idx), 32'(seg), 32'(exp_seg(v, idx)));
                    if (prev_idx >= 0)
                        chk($sformatf("%s_scan_order", tag), 32'(idx), 32'((prev_idx + 1) % 4));
                    prev_idx = idx;
                end
                $display("scan %s an=%b seg=%b value=%0d", tag, an, seg, v);
            end
        end
        chk({tag, "_scan_count"}, 32'(seen), 32'd4);
    endtask

    // One refresh cycle with v presented at the capture edge, `stall` cycles of
    // rd_gnt=0 first, and optionally a different result value after capture.
    task automatic run_fetch(input logic [31:0] v, input int stall, input bit corrupt,
                             input logic [31:0] corrupt_v, input bit restore, input string tag);
        int lat;
        rd_gnt = 1'b1;
        wait_busy(1'b0, tag);
        rd_gnt = (stall == 0);
        result = (stall == 0) ? v : $urandom;
        wait_busy(1'b1, tag);
        lat = 0;
        while (busy === 1'b1 && lat < 200) begin
            if (lat < stall) chk({tag, "_addr_stall"}, 32'(addr), 32'(BASE));
            if (lat == stall) begin
                rd_gnt = 1'b1;
                result = v;
            end
            if (lat == stall + 1 && corrupt) result = corrupt_v;
            lat++;
            step();
        end
        chk({tag, "_latency"}, 32'(lat), 32'(16 + stall));
        if (restore) result = v;
        chk({tag, "_overflow"}, 32'(overflow), 32'(v > 32'd9999));
        chk({tag, "_addr"}, 32'(addr), 32'(BASE));
        $display("fetch %s value=%0d stall=%0d latency=%0d overflow=%0b", tag, v, stall, lat, overflow);
        check_display(v, tag);
    endtask

    // Release reset (v already on result, rd_gnt high) and follow the first pass.
    task automatic post_release(input logic [31:0] v, input string tag);
        int lat;
        reset = 1'b0;
        step();
        chk({tag, "_rel_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rel_seg"}, 32'(seg), 32'h7F);
        lat = 1;
        step();
        while (busy === 1'b1 && lat < 200) begin
            lat++;
            step();
        end
        chk({tag, "_latency"}, 32'(lat), 32'd16);
        chk({tag, "_overflow"}, 32'(overflow), 32'(v > 32'd9999));
        $display("release %s value=%0d latency=%0d", tag, v, lat);
        check_display(v, tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_an"}, 32'(an), 32'hF);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_addr"}, 32'(addr), 32'(BASE));
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] cv;
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        reset  = 1'b1;
        rd_gnt = 1'b0;
        result = '0;

        // Reset held 3 cycles with arbitrary inputs.
        for (int i = 0; i < 3; i++) begin
            rd_gnt = 1'($urandom);
            result = $urandom;
            step();
        end
        chk_reset_outputs("reset");
        rd_gnt = 1'b1;
        result = 32'd1234;
        post_release(32'd1234, "v1234");

        run_fetch(32'd5678, 5, 1'b0, 32'd0, 1'b1, "stall5");
        run_fetch(32'd10000, 0, 1'b0, 32'd0, 1'b1, "v10000");
        run_fetch(32'hFFFFFFFF, 0, 1'b0, 32'd0, 1'b1, "vmax");

        // Abort a conversion of 1234 with a one-cycle reset.
        rd_gnt = 1'b1;
        result = 32'd1234;
        wait_busy(1'b0, "abort");
        wait_busy(1'b1, "abort");
        for (int i = 0; i < 5; i++) step();
        reset  = 1'b1;
        result = 32'd5678;
        step();
        chk_reset_outputs("abort_rst");
        post_release(32'd5678, "abort");

        run_fetch(32'd9999, 0, 1'b0, 32'd0, 1'b1, "v9999");
        run_fetch(32'd9, 0, 1'b1, 32'd42, 1'b0, "v9_then42");
        run_fetch(32'd42, 0, 1'b0, 32'd0, 1'b1, "v42");
        // Low 14 bits small but upper bits set: overflow must use all 32 bits.
        run_fetch(32'h0001_0005, 0, 1'b0, 32'd0, 1'b1, "vhigh");
        run_fetch(32'd0, 1, 1'b0, 32'd0, 1'b1, "v0");

        for (int k = 0; k < 4; k++) begin
            rv = $urandom_range(0, 9999);
            cv = $urandom;
            run_fetch(rv, int'($urandom_range(0, 3)), 1'b1, cv, 1'b1, $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
